// File: rtl/shot_clock_pkg.sv
// Shared types and constants for the two-digit BCD shot-clock countdown timer.
package shot_clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } timer_state_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam bcd_t WARN_LIMIT = 4'd5;

    // Loaded digits above 9 are forced to 9 so the counters only ever hold valid BCD.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/two_digits_decimal_down_timer_if.sv
// Control and display bus of the shot-clock timer: the game logic drives the master side,
// the timer sits on the slave side.
interface two_digits_decimal_down_timer_if;
    import shot_clock_pkg::*;

    logic loadN;
    logic start;
    logic pause;
    bcd_t datainL;
    bcd_t datainH;
    bcd_t countL;
    bcd_t countH;
    logic running;
    logic tc;
    logic expired;
    logic warn;

    modport master (
        output loadN, start, pause, datainL, datainH,
        input  countL, countH, running, tc, expired, warn
    );

    modport slave (
        input  loadN, start, pause, datainL, datainH,
        output countL, countH, running, tc, expired, warn
    );

endinterface

// File: rtl/bcd_digit_down_counter.sv
// One BCD digit counting down 9..0 with wrap to 9. Load beats enable; borrow-out flags
// an enabled step taken from 0 so the next digit up can decrement.
module bcd_digit_down_counter
    import shot_clock_pkg::*;
#(
    parameter bcd_t RESET_VAL = 4'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  bcd_t i_load_val,
    input  logic i_en,
    output bcd_t o_digit,
    output bcd_t o_digit_next,
    output logic o_borrow
);

    bcd_t r_digit;

    always_comb begin
        o_digit_next = r_digit;
        if (i_load) begin
            o_digit_next = i_load_val;
        end else if (i_en) begin
            o_digit_next = (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit <= RESET_VAL;
        end else begin
            r_digit <= o_digit_next;
        end
    end

    assign o_digit  = r_digit;
    assign o_borrow = i_en && (r_digit == 4'd0);

endmodule

// File: rtl/two_digits_decimal_down_timer.sv
// Two-digit BCD shot-clock countdown (99..00) with load, start, pause/resume and expiry.
// Optional low-time warning output is built only when SHOT_CLOCK_WARN_EN is defined.
module two_digits_decimal_down_timer
    import shot_clock_pkg::*;
#(
    parameter int   TICK_DIV  = 31_500_000,
    parameter bcd_t DEFAULT_H = 4'd3,
    parameter bcd_t DEFAULT_L = 4'd0
) (
    input  logic clk,
    input  logic reset,
    two_digits_decimal_down_timer_if.slave bus
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    timer_state_t    r_state;
    logic [PW-1:0]   r_presc;
    logic            r_running;
    logic            r_tc;
    logic            r_expired;

    logic            w_load;
    logic            w_step;
    logic            w_count_zero;
    logic            w_next_zero;
    logic [1:0]      w_en;
    logic [1:0]      w_borrow;
    bcd_t            w_load_val [2];
    bcd_t            w_digit    [2];
    bcd_t            w_next     [2];

    assign w_load        = !bus.loadN;
    assign w_load_val[0] = bcd_clamp(bus.datainL);
    assign w_load_val[1] = bcd_clamp(bus.datainH);

    assign w_step = (r_state == RUN) && !w_load && !bus.pause && (r_presc == PRESC_LAST);
    assign w_en[0] = w_step;
    assign w_en[1] = w_borrow[0];

    // Index 0 is the units digit, index 1 the tens digit fed by the units borrow.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit
            bcd_digit_down_counter #(
                .RESET_VAL ((gi == 0) ? DEFAULT_L : DEFAULT_H)
            ) u_digit (
                .clk          (clk),
                .reset        (reset),
                .i_load       (w_load),
                .i_load_val   (w_load_val[gi]),
                .i_en         (w_en[gi]),
                .o_digit      (w_digit[gi]),
                .o_digit_next (w_next[gi]),
                .o_borrow     (w_borrow[gi])
            );
        end
    endgenerate

    assign w_count_zero = (w_digit[1] == 4'd0) && (w_digit[0] == 4'd0);
    assign w_next_zero  = (w_next[1]  == 4'd0) && (w_next[0]  == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_tc      <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (w_load) begin
                r_state   <= IDLE;
                r_presc   <= '0;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (!bus.pause && bus.start) begin
                            if (w_count_zero) begin
                                r_state   <= EXPIRED;
                                r_tc      <= 1'b1;
                                r_expired <= 1'b1;
                            end else begin
                                r_state   <= RUN;
                                r_running <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            r_state   <= PAUSED;
                            r_running <= 1'b0;
                        // A tens borrow would mean stepping below 00; treat it as expiry too.
                        end else if (w_next_zero || w_borrow[1]) begin
                            r_state   <= EXPIRED;
                            r_running <= 1'b0;
                            r_tc      <= 1'b1;
                            r_expired <= 1'b1;
                            r_presc   <= '0;
                        end else begin
                            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
                        end
                    end
                    PAUSED: begin
                        if (!bus.pause && bus.start) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.countL  = w_digit[0];
    assign bus.countH  = w_digit[1];
    assign bus.running = r_running;
    assign bus.tc      = r_tc;
    assign bus.expired = r_expired;

`ifdef SHOT_CLOCK_WARN_EN
    logic r_warn;
    logic w_warn_active;

    // True when the state after this edge will be RUN or PAUSED.
    assign w_warn_active = !w_load &&
        (((r_state == RUN) && (bus.pause || !(w_next_zero || w_borrow[1]))) ||
         (r_state == PAUSED) ||
         ((r_state == IDLE) && bus.start && !bus.pause && !w_count_zero));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= w_warn_active && (w_next[1] == 4'd0) && (w_next[0] <= WARN_LIMIT);
        end
    end

    assign bus.warn = r_warn;
`else
    assign bus.warn = 1'b0;
`endif

endmodule

// File: tb/tb_two_digits_decimal_down_timer.sv
// Directed self-checking bench for the shot-clock timer with a 4-clock step period.
module tb_two_digits_decimal_down_timer;

`ifdef SHOT_CLOCK_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatched;

    two_digits_decimal_down_timer_if tif ();

    two_digits_decimal_down_timer #(
        .TICK_DIV  (4),
        .DEFAULT_H (4'd3),
        .DEFAULT_L (4'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_val);
        n_compared++;
        if (obs !== exp_val) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_val, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", tag, obs, $time);
        end
    endtask

    task automatic check_all(input string tag, input int h, input int l, input bit run,
                             input bit tc_e, input bit exp_e, input bit warn_e);
        check({tag, ".countH"},  int'(tif.countH),  h);
        check({tag, ".countL"},  int'(tif.countL),  l);
        check({tag, ".running"}, int'(tif.running), int'(run));
        check({tag, ".tc"},      int'(tif.tc),      int'(tc_e));
        check({tag, ".expired"}, int'(tif.expired), int'(exp_e));
        check({tag, ".warn"},    int'(tif.warn),    int'(warn_e & WARN_ON));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] h, input logic [3:0] l);
        tif.datainH = h;
        tif.datainL = l;
        tif.loadN   = 1'b0;
        tick(1);
        tif.loadN   = 1'b1;
    endtask

    task automatic pulse_start();
        tif.start = 1'b1;
        tick(1);
        tif.start = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        tif.loadN    = 1'b1;
        tif.start    = 1'b0;
        tif.pause    = 1'b0;
        tif.datainH  = 4'd0;
        tif.datainL  = 4'd0;
        #1;
        check_all("reset", 3, 0, 0, 0, 0, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        check_all("idle_after_reset", 3, 0, 0, 0, 0, 0);

        // 1: async reset in the middle of a run at 17
        do_load(4'd1, 4'd7);
        pulse_start();
        tick(2);
        check_all("t1_running_17", 1, 7, 1, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_all("t1_async_reset", 3, 0, 0, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check_all("t1_after_reset", 3, 0, 0, 0, 0, 0);

        // 2: 12 down to 00, tc for one cycle
        do_load(4'd1, 4'd2);
        pulse_start();
        check_all("t2_entry", 1, 2, 1, 0, 0, 0);
        tick(4);
        check_all("t2_11", 1, 1, 1, 0, 0, 0);
        tick(4);
        check_all("t2_10", 1, 0, 1, 0, 0, 0);
        tick(4);
        check_all("t2_09_borrow", 0, 9, 1, 0, 0, 0);
        tick(35);
        check_all("t2_01_at_47", 0, 1, 1, 0, 0, 1);
        tick(1);
        check_all("t2_00_at_48", 0, 0, 0, 1, 1, 0);
        tick(1);
        check_all("t2_tc_drops", 0, 0, 0, 0, 1, 0);
        tick(3);
        check_all("t2_expired_holds", 0, 0, 0, 0, 1, 0);

        // 3: pause with prescaler at 2, resume steps after 2 clocks
        do_load(4'd0, 4'd5);
        check_all("t3_loaded", 0, 5, 0, 0, 0, 0);
        pulse_start();
        tick(2);
        tif.pause = 1'b1;
        tick(1);
        check_all("t3_paused", 0, 5, 0, 0, 0, 1);
        tick(9);
        check_all("t3_paused_10clk", 0, 5, 0, 0, 0, 1);
        tif.pause = 1'b0;
        tif.start = 1'b1;
        tick(1);
        tif.start = 1'b0;
        check_all("t3_resumed", 0, 5, 1, 0, 0, 1);
        tick(1);
        check_all("t3_resume_plus1", 0, 5, 1, 0, 0, 1);
        tick(1);
        check_all("t3_resume_plus2", 0, 4, 1, 0, 0, 1);

        // 4: start+pause keeps PAUSED, start alone resumes
        tif.start = 1'b1;
        tif.pause = 1'b1;
        tick(1);
        check_all("t4_paused", 0, 4, 0, 0, 0, 1);
        tick(5);
        check_all("t4_start_and_pause", 0, 4, 0, 0, 0, 1);
        tif.pause = 1'b0;
        tick(1);
        check_all("t4_start_alone", 0, 4, 1, 0, 0, 1);
        tif.start = 1'b0;

        // 5: clamped load mid-run, load 00 then start expires immediately
        do_load(4'hC, 4'hF);
        check_all("t5_clamp_99", 9, 9, 0, 0, 0, 0);
        do_load(4'd2, 4'hA);
        check_all("t5_clamp_29", 2, 9, 0, 0, 0, 0);
        do_load(4'd0, 4'd0);
        check_all("t5_load_00", 0, 0, 0, 0, 0, 0);
        pulse_start();
        check_all("t5_start_at_00", 0, 0, 0, 1, 1, 0);
        tick(1);
        check_all("t5_tc_drops", 0, 0, 0, 0, 1, 0);
        tif.start = 1'b1;
        tick(3);
        check_all("t5_start_ignored", 0, 0, 0, 0, 1, 0);
        tif.start = 1'b0;

        // 6: warning window 05..01 through RUN and PAUSED, cleared at expiry
        do_load(4'd0, 4'd6);
        check_all("t6_loaded", 0, 6, 0, 0, 0, 0);
        pulse_start();
        check_all("t6_run_06", 0, 6, 1, 0, 0, 0);
        tick(4);
        check_all("t6_05_warn", 0, 5, 1, 0, 0, 1);
        tick(8);
        check_all("t6_03", 0, 3, 1, 0, 0, 1);
        tif.pause = 1'b1;
        tick(1);
        check_all("t6_paused_03", 0, 3, 0, 0, 0, 1);
        tif.pause = 1'b0;
        tif.start = 1'b1;
        tick(1);
        tif.start = 1'b0;
        tick(11);
        check_all("t6_01", 0, 1, 1, 0, 0, 1);
        tick(1);
        check_all("t6_expired", 0, 0, 0, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
